keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner for the calculator front end. It drives one column at a time, synchronises and debounces every key independently, and detects both press and release edges. Events are queued in a small FIFO and delivered downstream over a valid/ready handshake. It sits between the keypad pins and the calculator input decoder.

---
 rtl/keypad_if.sv | 17 +
 rtl/keypad_scanner.sv | 131 +++++++++++++
 tb/tb_keypad_scanner.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// Key-event handshake between the keypad scanner and the calculator input
// decoder.
//   key_valid   : head of the event queue holds an event (master -> slave)
//   key_ready   : consumer takes the head event this cycle (slave -> master)
//   key_code    : key index, col*ROWS+row (master -> slave)
//   key_release : 0 = press, 1 = release (master -> slave)
interface keypad_if #(
  parameter int CW = 4
);
  logic          key_valid;
  logic          key_ready;
  logic [CW-1:0] key_code;
  logic          key_release;

  modport master (output key_valid, output key_code, output key_release, input key_ready);
  modport slave  (input key_valid, input key_code, input key_release, output key_ready);
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one column at a time, synchronises the row
// lines, debounces every key independently and queues press/release events
// in a first-word-fall-through FIFO.
//   clk, rst   : clock, synchronous active-high reset
//   row_in     : raw row lines, active-high, asynchronous to clk
//   col_drive  : one-hot column drive, active-high
//   kif        : event handshake (valid/ready, code, release flag)
//   overflow   : one-cycle pulse when an event is dropped on a full FIFO
//   any_held   : at least one key is in the debounced pressed state
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_drive,
  keypad_if.master        kif,
  output logic            overflow,
  output logic            any_held
);
  localparam int NK   = ROWS * COLS;
  localparam int CW   = $clog2(NK);
  localparam int DW   = $clog2(SCAN_DIV);
  localparam int COLW = $clog2(COLS);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  logic [ROWS-1:0]          row_m, row_s, samp;
  logic [DW-1:0]            dcnt;
  logic [COLW-1:0]          col_idx, samp_col;
  logic                     samp_ok;
  logic [NK-1:0]            stable;
  logic [NK-1:0][3:0]       cnt;

  logic [RW-1:0]            r;
  logic [CW-1:0]            k;
  logic                     proc, diff, push;
  logic [CW:0]              push_data;

  logic [FIFO_DEPTH-1:0][CW:0] mem;
  logic [AW:0]              wptr, rptr;
  logic                     empty, full, pop, wr;

  // Scan timing, synchroniser and end-of-dwell row sampling
  always_ff @(posedge clk) begin
    if (rst) begin
      row_m     <= '0;
      row_s     <= '0;
      samp      <= '0;
      dcnt      <= '0;
      col_idx   <= '0;
      samp_col  <= '0;
      samp_ok   <= 1'b0;
      col_drive <= COLS'(1);
    end else begin
      row_m <= row_in;
      row_s <= row_m;
      if (dcnt == DW'(SCAN_DIV - 1)) begin
        dcnt      <= '0;
        samp      <= row_s;
        samp_col  <= col_idx;
        samp_ok   <= 1'b1;
        col_idx   <= (col_idx == COLW'(COLS - 1)) ? '0 : col_idx + 1'b1;
        col_drive <= {col_drive[COLS-2:0], col_drive[COLS-1]};
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  // One row of the last sampled column is evaluated per cycle while
  // dcnt < ROWS, so at most one event is generated per cycle.
  always_comb begin
    r         = dcnt[RW-1:0];
    k         = CW'(int'(samp_col) * ROWS + int'(r));
    proc      = samp_ok && (dcnt < DW'(ROWS));
    diff      = samp[r] != stable[k];
    push      = proc && diff && (cnt[k] == 4'(DEBOUNCE - 1));
    push_data = {~samp[r], k};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable   <= '0;
      cnt      <= '0;
      any_held <= 1'b0;
    end else begin
      any_held <= |stable;
      if (proc) begin
        if (!diff) begin
          cnt[k] <= '0;
        end else if (push) begin
          cnt[k]    <= '0;
          stable[k] <= ~stable[k];
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  // Event FIFO; a full FIFO still accepts a push when the head leaves the
  // same cycle, the written slot being the one just vacated.
  assign empty = (wptr == rptr);
  assign full  = ((wptr - rptr) == (AW+1)'(FIFO_DEPTH));
  assign pop   = !empty && kif.key_ready;
  assign wr    = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (wr) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  assign kif.key_valid                   = !empty;
  assign {kif.key_release, kif.key_code} = mem[rptr[AW-1:0]];
endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_drive;
  logic       overflow, any_held;
  logic [15:0] pressed = '0;

  keypad_if #(.CW(4)) kif();

  keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE(DEB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_drive(col_drive),
    .kif(kif), .overflow(overflow), .any_held(any_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column line to its row line.
  always_comb begin
    row_in = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        if (col_drive[c] && pressed[c*4+rr]) row_in[rr] = 1'b1;
  end

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed { logic [3:0] code; logic rel; } ev_t;
  ev_t exp_q[$];
  ev_t got_q[$];
  logic [15:0] m_stable;
  int          m_cnt [16];

  // Frame-level reference: every key sees one sample per frame, in key-index
  // order (column first, then row), and changes state after DEB differing
  // samples in a row.
  task automatic model_frame();
    ev_t e;
    for (int kk = 0; kk < 16; kk++) begin
      if (pressed[kk] == m_stable[kk]) m_cnt[kk] = 0;
      else begin
        m_cnt[kk]++;
        if (m_cnt[kk] == DEB) begin
          m_stable[kk] = ~m_stable[kk];
          m_cnt[kk]    = 0;
          e.code = 4'(kk);
          e.rel  = ~pressed[kk];
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Leaves the bench at the negedge right before the first post-reset edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pressed = '0;
    kif.key_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_stable = '0;
    for (int kk = 0; kk < 16; kk++) m_cnt[kk] = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    do_reset();
    tests_run++; if (col_drive !== 4'b0001) begin tests_failed++; $display("FAIL reset_col: got %b exp 0001", col_drive); end
    tests_run++; if (kif.key_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b exp 0", kif.key_valid); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b exp 0", overflow); end
    tests_run++; if (any_held !== 1'b0) begin tests_failed++; $display("FAIL reset_held: got %b exp 0", any_held); end
    tests_run++; if (kif.key_code !== 4'd0 || kif.key_release !== 1'b0) begin tests_failed++; $display("FAIL reset_head: got %0d/%b exp 0/0", kif.key_code, kif.key_release); end
    for (int cyc = 1; cyc <= 32; cyc++) begin
      @(negedge clk);
      exp_col = 4'(1 << ((cyc / 8) % 4));
      tests_run++; if (col_drive !== exp_col) begin tests_failed++; $display("FAIL col_rotate cyc %0d: got %b exp %b", cyc, col_drive, exp_col); end
    end
  endtask

  task automatic test_press_release();
    int n, first;
    logic [3:0] code;
    logic rel;
    do_reset();
    for (int phase = 0; phase < 2; phase++) begin
      pressed[5] = (phase == 0);
      n = 0; first = -1; code = 'x; rel = 'x;
      for (int cyc = phase*128 + 1; cyc <= phase*128 + 128; cyc++) begin
        @(negedge clk);
        if (kif.key_valid) begin
          n++;
          if (first < 0) begin first = cyc; code = kif.key_code; rel = kif.key_release; end
        end
      end
      tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL pr_count ph%0d: got %0d exp 1", phase, n); end
      tests_run++; if (first !== (phase == 0 ? 82 : 210)) begin tests_failed++; $display("FAIL pr_latency ph%0d: got cyc %0d exp %0d", phase, first, phase == 0 ? 82 : 210); end
      tests_run++; if (code !== 4'd5 || rel !== 1'(phase)) begin tests_failed++; $display("FAIL pr_event ph%0d: got %0d/%b exp 5/%0d", phase, code, rel, phase); end
      tests_run++; if (any_held !== (phase == 0)) begin tests_failed++; $display("FAIL pr_held ph%0d: got %b exp %0d", phase, any_held, phase == 0); end
    end
  endtask

  task automatic test_bounce();
    int nv, nh;
    do_reset();
    nv = 0; nh = 0;
    for (int cyc = 0; cyc < 192; cyc++) begin
      pressed[5] = (cyc < 64);
      @(negedge clk);
      if (kif.key_valid) nv++;
      if (any_held) nh++;
    end
    tests_run++; if (nv !== 0) begin tests_failed++; $display("FAIL bounce_events: got %0d exp 0", nv); end
    tests_run++; if (nh !== 0) begin tests_failed++; $display("FAIL bounce_held: got %0d cycles exp 0", nh); end
  endtask

  task automatic test_simultaneous();
    int cycs[$];
    logic [3:0] codes[$];
    do_reset();
    pressed[12] = 1'b1;
    pressed[14] = 1'b1;
    for (int cyc = 1; cyc <= 128; cyc++) begin
      @(negedge clk);
      if (kif.key_valid) begin cycs.push_back(cyc); codes.push_back(kif.key_code); end
    end
    tests_run++; if (cycs.size() !== 2) begin tests_failed++; $display("FAIL simul_count: got %0d exp 2", cycs.size()); end
    if (cycs.size() >= 2) begin
      tests_run++; if (codes[0] !== 4'd12 || cycs[0] !== 97) begin tests_failed++; $display("FAIL simul_first: got %0d@%0d exp 12@97", codes[0], cycs[0]); end
      tests_run++; if (codes[1] !== 4'd14 || cycs[1] !== 99) begin tests_failed++; $display("FAIL simul_second: got %0d@%0d exp 14@99", codes[1], cycs[1]); end
    end
  endtask

  task automatic test_overflow();
    int novf, ovf_cyc, f;
    logic [3:0] ecode [4] = '{4'd0, 4'd0, 4'd1, 4'd1};
    logic       erel  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    kif.key_ready = 1'b0;
    novf = 0; ovf_cyc = -1;
    for (int cyc = 0; cyc < 512; cyc++) begin
      f = cyc / 32;
      pressed = (f < 3) ? 16'h1 : (f < 6) ? 16'h0 : (f < 9) ? 16'h2 : (f < 12) ? 16'h0 : 16'h4;
      @(negedge clk);
      if (overflow) begin novf++; if (ovf_cyc < 0) ovf_cyc = cyc + 1; end
      if (cyc + 1 == 72) begin
        tests_run++; if (kif.key_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_pre_valid: got %b exp 0", kif.key_valid); end
      end
      if (cyc + 1 == 73) begin
        tests_run++; if (kif.key_valid !== 1'b1) begin tests_failed++; $display("FAIL ovf_first_valid: got %b exp 1", kif.key_valid); end
      end
    end
    tests_run++; if (novf !== 1) begin tests_failed++; $display("FAIL ovf_pulses: got %0d exp 1", novf); end
    tests_run++; if (ovf_cyc !== 459) begin tests_failed++; $display("FAIL ovf_cycle: got %0d exp 459", ovf_cyc); end
    kif.key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (kif.key_valid !== 1'b1 || kif.key_code !== ecode[i] || kif.key_release !== erel[i]) begin
        tests_failed++;
        $display("FAIL ovf_pop%0d: got v%b %0d/%b exp v1 %0d/%b", i, kif.key_valid, kif.key_code, kif.key_release, ecode[i], erel[i]);
      end
      @(negedge clk);
    end
    tests_run++; if (kif.key_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_drained: got %b exp 0", kif.key_valid); end
  endtask

  task automatic test_reset_mid();
    int n, first, novf;
    logic [3:0] code;
    do_reset();
    kif.key_ready = 1'b0;
    for (int cyc = 0; cyc < 192; cyc++) begin
      pressed = (cyc < 96) ? 16'h0021 : 16'h0020;
      @(negedge clk);
    end
    tests_run++; if (kif.key_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_queued: got %b exp 1", kif.key_valid); end
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (kif.key_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid: got %b exp 0", kif.key_valid); end
    tests_run++; if (any_held !== 1'b0) begin tests_failed++; $display("FAIL mid_held: got %b exp 0", any_held); end
    tests_run++; if (col_drive !== 4'b0001) begin tests_failed++; $display("FAIL mid_col: got %b exp 0001", col_drive); end
    novf = int'(overflow);
    repeat (2) begin @(negedge clk); novf += int'(overflow); end
    tests_run++; if (novf !== 0) begin tests_failed++; $display("FAIL mid_ovf: got %0d exp 0", novf); end
    rst = 1'b0;
    kif.key_ready = 1'b1;
    n = 0; first = -1; code = 'x;
    for (int cyc = 1; cyc <= 128; cyc++) begin
      @(negedge clk);
      if (kif.key_valid) begin n++; if (first < 0) begin first = cyc; code = kif.key_code; end end
    end
    tests_run++; if (n !== 1 || first !== 82 || code !== 4'd5) begin tests_failed++; $display("FAIL mid_repress: got n%0d %0d@%0d exp n1 5@82", n, code, first); end
  endtask

  task automatic test_random();
    logic prev_any;
    do_reset();
    for (int f = 0; f < 60; f++) begin
      if (f < 48) begin
        if ($urandom_range(0, 2) == 0) pressed[$urandom_range(0, 15)] ^= 1'b1;
        if ($urandom_range(0, 4) == 0) pressed[$urandom_range(0, 15)] ^= 1'b1;
      end
      prev_any = |m_stable;
      model_frame();
      for (int i = 1; i <= 32; i++) begin
        if (kif.key_valid && kif.key_ready) got_q.push_back({kif.key_code, kif.key_release});
        @(negedge clk);
        if (i == 8) begin
          tests_run++; if (any_held !== prev_any) begin tests_failed++; $display("FAIL rnd_held frame %0d: got %b exp %b", f, any_held, prev_any); end
        end
      end
    end
    tests_run++; if (got_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL rnd_count: got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL rnd_event%0d: got %0d/%b exp %0d/%b", i, got_q[i].code, got_q[i].rel, exp_q[i].code, exp_q[i].rel);
      end
    end
  endtask

  initial begin
    kif.key_ready = 1'b1;
    test_reset();
    test_press_release();
    test_bounce();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
